decrementer: RTL

DECREMENTER -- requirements
Module: decrementer

---
 rtl/decrementer_pkg.sv | 13 +
 rtl/decrementer_dec_cell.sv | 20 ++
 rtl/decrementer.sv | 108 ++++++++++
 3 files changed

// File: rtl/decrementer_pkg.sv
// Shared definitions for the multi-cycle decrementer: FSM state encoding
// and the default operand width.
package decrementer_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/decrementer_dec_cell.sv
// Single-step decrement cell: produces a-1 (mod 2^W) and a borrow bit that is
// set exactly when the input is zero and the step wraps around.
module dec_cell
    import decrementer_pkg::*;
#(
    parameter int W = WIDTH_DEFAULT
) (
    input  logic [W-1:0] i_a,
    output logic [W-1:0] o_diff,
    output logic         o_borrow
);

    logic [W:0] w_ext;

    // Extend by one bit so the top bit of the subtraction is the borrow.
    assign w_ext    = {1'b0, i_a} - (W+1)'(1);
    assign o_diff   = w_ext[W-1:0];
    assign o_borrow = w_ext[W];

endmodule

// File: rtl/decrementer.sv
// Multi-cycle decrementer: accepts (A, K), subtracts one per cycle K times,
// then presents S = (A-K) mod 2^WIDTH and a sticky borrow until the result
// is taken by the consumer.
module decrementer
    import decrementer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] K,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             B_out,
    output logic             busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_cnt;
    logic             r_borrow;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_acc_dec;
    logic             w_step_borrow;

    // The one decrement step applied to the accumulator each RUN cycle.
    dec_cell #(
        .W (WIDTH)
    ) u_dec_cell (
        .i_a      (r_acc),
        .o_diff   (w_acc_dec),
        .o_borrow (w_step_borrow)
    );

    // FSM plus datapath registers; handshake flags are registered alongside
    // the state so every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_acc      <= A;
                        r_cnt      <= K;
                        r_borrow   <= 1'b0;
                        r_in_ready <= 1'b0;
                        if (K != '0) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            // Zero steps: result is A itself, available next cycle.
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_dec;
                    r_cnt <= r_cnt - WIDTH'(1);
                    if (w_step_borrow) begin
                        r_borrow <= 1'b1;
                    end
                    if (r_cnt == WIDTH'(1)) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Return to IDLE on the result handshake; a new request can
                    // only be accepted on the following cycle.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign S         = r_acc;
    assign B_out     = r_borrow;

endmodule
